seq_encoder_8to3: RTL and testbench
===================================

Name: seq_encoder_8to3

Overview:
- Inverse of the team's 3x8 decoder: accepts an 8-bit request word and serialises every set bit into a stream of 3-bit binary codes, one per output handshake.
- Sits between request-collecting logic (interrupt or event lines) and downstream consumers that expect one encoded index at a time.
- Valid/ready on both sides; word-level flow control on input, code-level on output.

Parameters:
- IN_W, 8, input word width; must equal 2**CODE_W.
- CODE_W, 3, output code width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_word is valid.
- in_ready  output  1  block can accept a word.
- in_word  input  IN_W  request bits; bit i maps to code i.
- out_valid  output  1  out_code/out_last/out_none valid.
- out_ready  input  1  downstream accepts current beat.
- out_code  output  CODE_W  index of the currently selected set bit.
- out_last  output  1  current beat is the final beat of this word.
- out_none  output  1  accepted word was all-zero; the beat carries no index.
- busy  output  1  high while a word is being emitted (state EMIT).

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst), sampled on the rising edge.
- Reset values: state=IDLE, pending=0, none_r=0, in_ready=1, out_valid=0, out_code=0, out_last=0, out_none=0, busy=0.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready at edge N: pending<=in_word, none_r<=(in_word==0), state<=EMIT.
- State EMIT:
  - in_ready=0, out_valid=1, busy=1.
  - out_code = index of the lowest set bit of pending, combinational from registers.
  - out_last = popcount(pending)<=1. out_none=none_r.
- Latency: first beat is visible in cycle N+1, the first cycle after acceptance.
- Throughput: one beat per cycle while out_ready=1.
- On out_valid && out_ready:
  - Clear the selected bit in pending.
  - If out_last: state<=IDLE, none_r<=0. in_ready is 1 in the following cycle, so there is one idle bubble between words.
- out_ready low: hold pending and all outputs stable; out_valid stays 1 and must not be withdrawn.
- Zero word: exactly one beat with out_code=0, out_none=1, out_last=1.
- in_valid while in_ready=0: ignored; the word is not captured and the source must hold it.
- in_word=8'hFF: 8 beats, codes 0..7, out_last only on code 7.
- Reset in EMIT: the remaining pending bits are discarded. out_valid=0 and in_ready=1 in the cycle after the reset edge.
- rst dominates all simultaneous handshakes.
- No arithmetic beyond the bit index. out_code is exactly CODE_W bits, with no wrap.

Optional Feature:
- Macro ENC_MSB_FIRST_EN.
- Defined: the selector picks the highest set bit of pending, so codes are emitted in descending order. out_last is unchanged (popcount<=1).
- Undefined (default): lowest set bit first, ascending order.
- out_none behaviour is identical in both builds.

Decomposition:
- Package enc_pkg holds:
  - localparams IN_W=8 and CODE_W=3.
  - state enum type enc_state_t {IDLE, EMIT}.
  - function onehot_clear(word, idx).
- One sub-module, prio_sel8: purely combinational.
  - Inputs: pending[7:0].
  - Outputs: code[2:0] and single (popcount<=1).
  - ENC_MSB_FIRST_EN selects the search direction inside it.
- The top level keeps the FSM, the pending register and the handshakes.

Test Plan:
- Reset then in_word=8'b0010_0101, out_ready=1 → codes 0,2,5 on consecutive cycles N+1..N+3; out_last only with code 5; in_ready=1 at N+4.
- in_word=8'h00 → a single beat with out_code=0, out_none=1, out_last=1; back to IDLE the next cycle.
- in_word=8'b1000_0010, out_ready low for 3 cycles after the first beat → code 1 held stable for 3 cycles, then codes 1 and 7; no beat lost or duplicated.
- in_word=8'hFF with in_valid held high throughout → 8 beats (codes 0..7); the second word is not accepted until in_ready=1 after code 7.
- rst pulsed high while in EMIT after code 0 of 8'h0F → the next cycle shows out_valid=0, in_ready=1, busy=0; a new word 8'h10 then emits code 4 only.
- Built with ENC_MSB_FIRST_EN, in_word=8'b0010_0101 → codes 5,2,0; out_last with code 0.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared types and helpers for the 8-to-3 sequential encoder.
// Widths are fixed: IN_W must equal 2**CODE_W.
package enc_pkg;

  localparam int IN_W   = 8;
  localparam int CODE_W = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } enc_state_t;

  function automatic logic [IN_W-1:0] onehot_clear(
    input logic [IN_W-1:0]   word,
    input logic [CODE_W-1:0] idx
  );
    logic [IN_W-1:0] mask;
    mask      = '0;
    mask[idx] = 1'b1;
    return word & ~mask;
  endfunction

endpackage

// File: rtl/prio_sel8.sv
// Combinational priority selector over the pending request bits.
// ENC_MSB_FIRST_EN picks the highest set bit; default picks the lowest.
module prio_sel8
  import enc_pkg::*;
(
  input  logic [IN_W-1:0]   pending,
  output logic [CODE_W-1:0] code,
  output logic              single
);

  always_comb begin
    code = '0;
`ifdef ENC_MSB_FIRST_EN
    for (int i = 0; i < IN_W; i++)
      if (pending[i]) code = CODE_W'(i);
`else
    for (int i = IN_W - 1; i >= 0; i--)
      if (pending[i]) code = CODE_W'(i);
`endif
  end

  // at most one bit set: clearing the lowest set bit leaves zero
  assign single = (pending & (pending - IN_W'(1))) == '0;

endmodule

// File: rtl/seq_encoder_8to3.sv
// Serialises each set bit of a request word into 3-bit codes.
// Optional ENC_MSB_FIRST_EN (in prio_sel8) emits codes in descending order.
module seq_encoder_8to3
  import enc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_last,
  output logic              out_none,
  output logic              busy
);

  enc_state_t      state_q, state_d;
  logic [IN_W-1:0] pending_q, pending_d;
  logic            none_q, none_d;

  logic [CODE_W-1:0] sel_code;
  logic              sel_single;

  prio_sel8 u_sel (
    .pending (pending_q),
    .code    (sel_code),
    .single  (sel_single)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    none_d    = none_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          pending_d = in_word;
          none_d    = (in_word == '0);
          state_d   = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          pending_d = onehot_clear(pending_q, sel_code);
          if (sel_single) begin
            state_d = IDLE;
            none_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      none_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      none_q    <= none_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign busy      = (state_q == EMIT);
  assign out_code  = out_valid ? sel_code : '0;
  assign out_last  = out_valid & sel_single;
  assign out_none  = out_valid & none_q;

endmodule

// File: tb/tb_seq_encoder_8to3.sv
// Directed bench for seq_encoder_8to3.
// Honours ENC_MSB_FIRST_EN for the expected code order.
module tb_seq_encoder_8to3;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_word;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_code;
  logic       out_last;
  logic       out_none;
  logic       busy;

  int checks = 0;
  int errors = 0;

  seq_encoder_8to3 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_last  (out_last),
    .out_none  (out_none),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(
    input string      tag,
    input logic       v,
    input logic [2:0] c,
    input logic       l,
    input logic       n
  );
    chk({tag, ".valid"}, 8'(out_valid), 8'(v));
    chk({tag, ".code"},  8'(out_code),  8'(c));
    chk({tag, ".last"},  8'(out_last),  8'(l));
    chk({tag, ".none"},  8'(out_none),  8'(n));
    chk({tag, ".ready"}, 8'(in_ready),  8'(!v));
    chk({tag, ".busy"},  8'(busy),      8'(v));
  endtask

  function automatic logic [2:0] ord(input int k, input int n);
`ifdef ENC_MSB_FIRST_EN
    return 3'(n - 1 - k);
`else
    return 3'(k);
`endif
  endfunction

  logic [2:0] c25 [3];
  logic [2:0] c82 [2];
  logic [2:0] c0f_first;

  initial begin
`ifdef ENC_MSB_FIRST_EN
    c25 = '{3'd5, 3'd2, 3'd0};
    c82 = '{3'd7, 3'd1};
    c0f_first = 3'd3;
`else
    c25 = '{3'd0, 3'd2, 3'd5};
    c82 = '{3'd1, 3'd7};
    c0f_first = 3'd0;
`endif
    rst = 1'b1;
    in_valid = 1'b0;
    in_word = 8'h00;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    beat("reset", 1'b0, 3'd0, 1'b0, 1'b0);

    // 0010_0101 at full rate
    in_word = 8'b0010_0101;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      beat($sformatf("w25.b%0d", k), 1'b1, c25[k], k == 2, 1'b0);
      tick();
    end
    beat("w25.idle", 1'b0, 3'd0, 1'b0, 1'b0);

    // all-zero word
    in_word = 8'h00;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    beat("zero.b0", 1'b1, 3'd0, 1'b1, 1'b1);
    tick();
    beat("zero.idle", 1'b0, 3'd0, 1'b0, 1'b0);

    // backpressure on 1000_0010
    in_word = 8'b1000_0010;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    beat("bp.b0", 1'b1, c82[0], 1'b0, 1'b0);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      beat($sformatf("bp.hold%0d", k), 1'b1, c82[0], 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    beat("bp.b1", 1'b1, c82[1], 1'b1, 1'b0);
    tick();
    beat("bp.idle", 1'b0, 3'd0, 1'b0, 1'b0);

    // FF with in_valid held high
    in_word = 8'hFF;
    in_valid = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      beat($sformatf("ff.b%0d", k), 1'b1, ord(k, 8), k == 7, 1'b0);
      tick();
    end
    beat("ff.bubble", 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    beat("ff2.b0", 1'b1, ord(0, 8), 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) tick();
    beat("ff2.idle", 1'b0, 3'd0, 1'b0, 1'b0);

    // reset mid-word; simultaneous in_valid must be ignored
    in_word = 8'h0F;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    beat("rst.b0", 1'b1, c0f_first, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    in_valid = 1'b1;
    in_word = 8'h80;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    beat("rst.after", 1'b0, 3'd0, 1'b0, 1'b0);
    in_word = 8'h10;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    beat("w10.b0", 1'b1, 3'd4, 1'b1, 1'b0);
    tick();
    beat("w10.idle", 1'b0, 3'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
